// File: rtl/handshake_if.sv
`default_nettype none
// ============================================================================
// Module      : handshake_if
// Description : Source-side and destination-side valid/ready signals of the
//               handshake slice.
// Revision    : 1.0 - initial release
// ============================================================================
interface handshake_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  valid_s;
    logic [DATA_WIDTH-1:0] data_s;
    logic                  ready_s;
    logic                  valid_d;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  ready_d;

    // master is the environment around the slice: it feeds the source side and sinks the destination side
    modport master (
        output valid_s, data_s, ready_d,
        input  ready_s, valid_d, data_d
    );

    modport slave (
        input  valid_s, data_s, ready_d,
        output ready_s, valid_d, data_d
    );
endinterface
`default_nettype wire

// File: rtl/handshake.sv
`default_nettype none
// ============================================================================
// Module      : handshake
// Description : Fully registered valid/ready skid buffer (one main + one skid word).
// Revision    : 1.0 - initial release
// ============================================================================
module handshake #(
    parameter int DATA_WIDTH = 8
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    handshake_if.slave  bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_main_data;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic                  r_valid_d;
    logic                  r_ready_s;

    assign bus.valid_d = r_valid_d;
    assign bus.data_d  = r_main_data;
    assign bus.ready_s = r_ready_s;

    // Outputs are state-derived flops, so no input reaches an output combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_main_data <= '0;
            r_skid_data <= '0;
            r_valid_d   <= 1'b0;
            r_ready_s   <= 1'b1;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (bus.valid_s) begin
                        r_main_data <= bus.data_s;
                        r_valid_d   <= 1'b1;
                        r_state     <= BUSY;
                    end
                end
                BUSY: begin
                    case ({bus.valid_s, bus.ready_d})
                        2'b11: r_main_data <= bus.data_s;
                        2'b10: begin
                            r_skid_data <= bus.data_s;
                            r_ready_s   <= 1'b0;
                            r_state     <= FULL;
                        end
                        2'b01: begin
                            r_valid_d <= 1'b0;
                            r_state   <= EMPTY;
                        end
                        default: ;
                    endcase
                end
                FULL: begin
                    if (bus.ready_d) begin
                        r_main_data <= r_skid_data;
                        r_ready_s   <= 1'b1;
                        r_state     <= BUSY;
                    end
                end
                default: begin
                    r_state   <= EMPTY;
                    r_valid_d <= 1'b0;
                    r_ready_s <= 1'b1;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_handshake.sv
`default_nettype none
// ============================================================================
// Module      : tb_handshake
// Description : Self-checking bench: directed vector table, async-reset case,
//               and random traffic against a two-entry FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_handshake;
    localparam int DW = 8;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    handshake_if #(.DATA_WIDTH(DW)) bus ();

    handshake #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          vs;
        logic [DW-1:0] ds;
        logic          rd;
        logic          exp_vd;
        logic [DW-1:0] exp_dd;
        logic          exp_rs;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic vs, input logic [DW-1:0] ds, input logic rd);
        bus.valid_s = vs;
        bus.data_s  = ds;
        bus.ready_d = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int i, input logic vs, input logic [DW-1:0] ds, input logic rd,
                           input logic evd, input logic [DW-1:0] edd, input logic ers);
        vecs[i].vs     = vs;
        vecs[i].ds     = ds;
        vecs[i].rd     = rd;
        vecs[i].exp_vd = evd;
        vecs[i].exp_dd = edd;
        vecs[i].exp_rs = ers;
    endtask

    // Reference: the slice behaves as a FIFO of depth two presenting its head
    logic [DW-1:0] q[$];

    initial begin
        logic [DW-1:0] xval;
        total = 0;
        bad   = 0;
        xval  = 'x;
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_valid_d", 32'(bus.valid_d), 32'd0);
        chk("reset_data_d",  32'(bus.data_d),  32'd0);
        chk("reset_ready_s", 32'(bus.ready_s), 32'd1);
        rst_n = 1'b1;

        //          vs    data   rd    exp_vd exp_dd exp_rs
        set_vec(0,  1'b1, 8'h08, 1'b0, 1'b1, 8'h08, 1'b1);
        set_vec(1,  1'b1, 8'h35, 1'b0, 1'b1, 8'h08, 1'b0);
        set_vec(2,  1'b1, 8'h35, 1'b1, 1'b1, 8'h35, 1'b1);
        set_vec(3,  1'b1, 8'hac, 1'b1, 1'b1, 8'hac, 1'b1);
        set_vec(4,  1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
        set_vec(5,  1'b1, 8'hee, 1'b1, 1'b1, 8'hee, 1'b1);
        set_vec(6,  1'b1, 8'h23, 1'b1, 1'b1, 8'h23, 1'b1);
        set_vec(7,  1'b1, 8'haa, 1'b1, 1'b1, 8'haa, 1'b1);
        set_vec(8,  1'b1, 8'hcd, 1'b1, 1'b1, 8'hcd, 1'b1);
        set_vec(9,  1'b1, 8'h98, 1'b0, 1'b1, 8'hcd, 1'b0);
        set_vec(10, 1'b1, 8'h11, 1'b1, 1'b1, 8'h98, 1'b1);
        set_vec(11, 1'b1, 8'h11, 1'b1, 1'b1, 8'h11, 1'b1);
        set_vec(12, 1'b0, xval,  1'b1, 1'b0, 8'h00, 1'b1);
        set_vec(13, 1'b1, 8'h4f, 1'b1, 1'b1, 8'h4f, 1'b1);
        set_vec(14, 1'b1, 8'hac, 1'b1, 1'b1, 8'hac, 1'b1);
        set_vec(15, 1'b0, xval,  1'b1, 1'b0, 8'h00, 1'b1);

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].vs, vecs[i].ds, vecs[i].rd);
            step();
            chk($sformatf("vec%0d_valid_d", i), 32'(bus.valid_d), 32'(vecs[i].exp_vd));
            chk($sformatf("vec%0d_ready_s", i), 32'(bus.ready_s), 32'(vecs[i].exp_rs));
            if (vecs[i].exp_vd) begin
                chk($sformatf("vec%0d_data_d", i), 32'(bus.data_d), 32'(vecs[i].exp_dd));
                chk($sformatf("vec%0d_data_known", i), 32'($isunknown(bus.data_d)), 32'd0);
            end
        end

        // Fill both registers, then reset asynchronously between clock edges
        drive(1'b1, 8'h5a, 1'b0);
        step();
        drive(1'b1, 8'hc3, 1'b0);
        step();
        chk("fill_ready_s", 32'(bus.ready_s), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid_d", 32'(bus.valid_d), 32'd0);
        chk("async_rst_ready_s", 32'(bus.ready_s), 32'd1);
        chk("async_rst_data_d",  32'(bus.data_d),  32'd0);
        // Inputs toggling during reset must not load anything
        drive(1'b1, 8'h77, 1'b1);
        step();
        chk("in_rst_valid_d", 32'(bus.valid_d), 32'd0);
        @(negedge clk);
        drive(1'b0, '0, 1'b0);
        rst_n = 1'b1;

        // Random traffic against the FIFO model
        q.delete();
        for (int c = 0; c < 2000; c++) begin
            logic          vs;
            logic          rd;
            logic [DW-1:0] ds;
            logic          acc_in;
            logic          acc_out;
            vs = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 2) != 0);
            ds = DW'($urandom);
            if (!vs && ($urandom_range(0, 1) == 1)) ds = 'x;
            drive(vs, ds, rd);
            acc_in  = vs && (q.size() < 2);
            acc_out = rd && (q.size() > 0);
            if (c == 1000) begin
                @(negedge clk);
                rst_n = 1'b0;
                #1;
                q.delete();
                chk("rand_rst_valid_d", 32'(bus.valid_d), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                continue;
            end
            step();
            if (acc_out) void'(q.pop_front());
            if (acc_in) q.push_back(ds);
            chk("rand_valid_d", 32'(bus.valid_d), 32'(q.size() > 0));
            chk("rand_ready_s", 32'(bus.ready_s), 32'(q.size() < 2));
            if (q.size() > 0)
                chk("rand_data_d", 32'(bus.data_d), 32'(q[0]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
